// File: rtl/ppa_pkg.sv
// Shared definitions for the parallel-prefix adder/subtractor family.
package ppa_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned SPLIT_DEFAULT = 16;

    // Generate/propagate pair for one bit or one bit group.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: (g,p) o (g',p') = (g | p&g', p&p'), hi is the more significant group.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ppa_prefix_n.sv
// Combinational N-bit Kogge-Stone adder: s = a + b + cin, cout = carry out of bit N-1.
module ppa_prefix_n
    import ppa_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 1;

    gp_t        tree [LEVELS+1][N];
    logic [N:0] carry;

    // Prefix tree; cin is folded into bit 0's generate so every group term includes it.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            tree[0][i].g = a[i] & b[i];
            tree[0][i].p = a[i] ^ b[i];
        end
        tree[0][0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (i >= (1 << l)) begin
                    tree[l+1][i] = gp_combine(tree[l][i], tree[l][i - (1 << l)]);
                end else begin
                    tree[l+1][i] = tree[l][i];
                end
            end
        end
    end

    // Carry into each bit is the group generate of everything below it.
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            carry[i+1] = tree[LEVELS][i].g;
            s[i]       = tree[0][i].p ^ carry[i];
        end
        cout = carry[N];
    end

endmodule

// File: rtl/ppa_sub_pipe_32.sv
// Two-stage pipelined subtractor D = A - B - Bin with valid/ready on both sides.
module ppa_sub_pipe_32
    import ppa_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned SPLIT = SPLIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int unsigned HI = WIDTH - SPLIT;

    // Stage 1 registers: resolved low half plus the operands the upper half still needs.
    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HI-1:0]    s1_a_hi;
    logic [HI-1:0]    s1_nb_hi;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic             s1_adv;
    logic             s2_adv;

    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI-1:0]    hi_sum;
    logic             hi_cout;
    logic [WIDTH-1:0] d_next;

    // Subtraction as A + ~B + ~Bin: low half ahead of stage 1.
    ppa_prefix_n #(.N(SPLIT)) u_lo (
        .a    (A[SPLIT-1:0]),
        .b    (~B[SPLIT-1:0]),
        .cin  (~Bin),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    // Upper half ahead of stage 2, fed by the registered mid carry.
    ppa_prefix_n #(.N(HI)) u_hi (
        .a    (s1_a_hi),
        .b    (s1_nb_hi),
        .cin  (s1_c),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    // Ready chain: a stage may load when it is empty or its successor is draining.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
        d_next   = {hi_sum, s1_lo};
    end

    // Stage 1 register: captures operands on an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c     <= 1'b0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo    <= lo_sum;
                s1_c     <= lo_cout;
                s1_a_hi  <= A[WIDTH-1:SPLIT];
                s1_nb_hi <= ~B[WIDTH-1:SPLIT];
                s1_a_msb <= A[WIDTH-1];
                s1_b_msb <= B[WIDTH-1];
            end
        end
    end

    // Stage 2 / output register: result and flags, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                D    <= d_next;
                Bout <= ~hi_cout;
                V    <= (s1_a_msb ^ s1_b_msb) & (d_next[WIDTH-1] ^ s1_a_msb);
                Z    <= (d_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_ppa_sub_pipe_32.sv
// Directed self-checking bench for the pipelined subtractor.
module tb_ppa_sub_pipe_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int n_checks = 0;
    int n_errors = 0;

    ppa_sub_pipe_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] ed, input logic eb,
                             input logic ev, input logic ez);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".D"},     64'(D),         64'(ed));
        check({tag, ".Bout"},  64'(Bout),      64'(eb));
        check({tag, ".V"},     64'(V),         64'(ev));
        check({tag, ".Z"},     64'(Z),         64'(ez));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic bin);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Bin      = bin;
    endtask

    // One isolated transaction with out_ready held high; result is due on the 2nd edge.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] ed, input logic eb,
                           input logic ev, input logic ez);
        out_ready = 1'b1;
        drive(a, b, bin);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        A        = 32'hDEAD_BEEF;
        B        = 32'h0BAD_F00D;
        check({tag, ".early"}, 64'(out_valid), 64'd0);
        step();
        check_res(tag, ed, eb, ev, ez);
        step();
        check({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        #12;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.D",         64'(D),         64'd0);
        check("rst.flags",     64'({Bout, V, Z}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst.in_ready", 64'(in_ready), 64'd1);

        // Single transactions, including borrows across the pipeline cut and overflow.
        run_one("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_one("neg1",   32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("split",  32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        run_one("ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one("eqbin",  32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("zbin",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("ovfneg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream at full throughput.
        out_ready = 1'b1;
        drive(32'h9ABC_DEF0, 32'h1234_5678, 1'b0);
        step();
        check("str.t0.in_ready", 64'(in_ready), 64'd1);
        check("str.t0.early",    64'(out_valid), 64'd0);
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        step();
        check_res("str.r0", 32'h8888_8878, 1'b0, 1'b0, 1'b0);
        check("str.t1.in_ready", 64'(in_ready), 64'd1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        check_res("str.r1", 32'h5555_5555, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        check_res("str.r2", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        step();
        check("str.drain", 64'(out_valid), 64'd0);

        // Same stream under backpressure: two buffered, third waits, order preserved.
        out_ready = 1'b0;
        drive(32'h9ABC_DEF0, 32'h1234_5678, 1'b0);
        step();
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        check("bp.t1.in_ready", 64'(in_ready), 64'd1);
        step();
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("bp.full.in_ready", 64'(in_ready), 64'd0);
        check_res("bp.hold0", 32'h8888_8878, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("bp.hold%0d.in_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("bp.hold%0d.D", k),        64'(D),        64'h8888_8878);
            check($sformatf("bp.hold%0d.valid", k),    64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_res("bp.r1", 32'h5555_5555, 1'b0, 1'b1, 1'b0);
        step();
        check_res("bp.r2", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        step();
        check("bp.drain", 64'(out_valid), 64'd0);

        // Reset with two transactions in flight clears outputs asynchronously.
        out_ready = 1'b0;
        drive(32'h0000_0005, 32'h0000_0003, 1'b0);
        step();
        drive(32'h0000_0009, 32'h0000_0001, 1'b0);
        step();
        in_valid = 1'b0;
        check_res("fl.before", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("fl.rst.valid", 64'(out_valid), 64'd0);
        check("fl.rst.D",     64'(D),         64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("fl.stale%0d", k), 64'(out_valid), 64'd0);
        end
        run_one("fl.next", 32'h0000_0064, 32'h0000_0032, 1'b0, 32'h0000_0032, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
